// File: rtl/q_arb_pkg.sv
// Shared types and helpers for the circ_q write arbiter and its priority picker.
package q_arb_pkg;

   // Largest requester count the picker helper supports.
   localparam int MAX_REQ       = 16;
   // Default longest lock a single producer may hold, in beats.
   localparam int DEF_MAX_BURST = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_e;

   typedef struct packed {
      logic       found;
      logic [3:0] idx;
   } rr_pick_t;

   // First set bit of req, searching ptr, ptr+1, ... modulo n.
   function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                        input logic [3:0]         ptr,
                                        input int unsigned        n);
      rr_pick_t    res;
      int unsigned k;
      res = '0;
      for (int unsigned i = 0; i < MAX_REQ; i++) begin
         k = (int'(ptr) + i) % n;
         if ((i < n) && !res.found && req[4'(k)]) begin
            res.found = 1'b1;
            res.idx   = 4'(k);
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/q_wr_arbiter_rr_prio_pick.sv
// Rotating-priority encoder: picks the first active request at or after ptr.
module rr_prio_pick
   import q_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic               found,
   output logic [ID_W-1:0]    idx
);

   rr_pick_t pick;

   // Rotate-search the request vector starting from ptr.
   always_comb begin
      pick  = rr_pick(MAX_REQ'(req), 4'(ptr), NUM_REQ);
      found = pick.found;
      idx   = ID_W'(pick.idx);
   end

endmodule

// File: rtl/q_wr_arbiter.sv
// Round-robin write arbiter sharing one circ_q among NUM_REQ producers,
// with an optional packet lock so a producer's beats are not interleaved.
module q_wr_arbiter
   import q_arb_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int WORD_SZ   = 32,
   parameter int MAX_BURST = DEF_MAX_BURST,
   parameter int ID_W      = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ-1:0]         last,
   input  logic [NUM_REQ*WORD_SZ-1:0] data_in,
   input  logic                       q_full,
   output logic [NUM_REQ-1:0]         gnt,
   output logic [ID_W-1:0]            gnt_id,
   output logic                       locked,
   output logic                       q_wr,
   output logic [WORD_SZ-1:0]         q_data
);

   if (ID_W != $clog2(NUM_REQ)) begin : g_bad_id_w
      $error("q_wr_arbiter: ID_W must equal clog2(NUM_REQ)");
   end
   if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
      $error("q_wr_arbiter: NUM_REQ must be in 2..16");
   end
   if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_max_burst
      $error("q_wr_arbiter: MAX_BURST must be in 1..255");
   end

   localparam bit CAN_LOCK = (MAX_BURST > 1);

   arb_state_e      state_q,     state_d;
   logic [ID_W-1:0] owner_q,     owner_d;
   logic [ID_W-1:0] rr_ptr_q,    rr_ptr_d;
   logic [7:0]      burst_cnt_q, burst_cnt_d;
   logic [ID_W-1:0] gnt_id_q,    gnt_id_d;
   logic            locked_q,    locked_d;

   logic            cand_found;
   logic [ID_W-1:0] cand_idx;
   logic            grant_en;
   logic [ID_W-1:0] grant_idx;
   logic [8:0]      burst_next;
   logic            burst_done;

   // Successor index, wrapping at NUM_REQ rather than 2^ID_W.
   function automatic logic [ID_W-1:0] next_idx(input logic [ID_W-1:0] i);
      return (i == ID_W'(NUM_REQ - 1)) ? '0 : i + ID_W'(1);
   endfunction

   rr_prio_pick #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_pick (
      .req   (req),
      .ptr   (rr_ptr_q),
      .found (cand_found),
      .idx   (cand_idx)
   );

   // Same-cycle grant: the owner alone while locked, else the round-robin candidate.
   always_comb begin
      grant_idx = (state_q == BURST) ? owner_q : cand_idx;
      grant_en  = !rst && !q_full &&
                  ((state_q == BURST) ? req[owner_q] : cand_found);
      gnt       = grant_en ? (NUM_REQ'(1) << grant_idx) : '0;
      q_wr      = grant_en;
      q_data    = grant_en ? data_in[grant_idx*WORD_SZ +: WORD_SZ] : '0;
   end

   // Next-state logic for the lock, burst counter and round-robin pointer.
   always_comb begin
      // NOTE: every variable gets a hold value first so no path leaves it
      // unassigned, which would infer a latch.
      state_d     = state_q;
      owner_d     = owner_q;
      rr_ptr_d    = rr_ptr_q;
      burst_cnt_d = burst_cnt_q;
      gnt_id_d    = gnt_id_q;
      burst_next  = {1'b0, burst_cnt_q} + 9'd1;
      burst_done  = last[owner_q] || (burst_next >= 9'(MAX_BURST));

      if (grant_en) begin
         gnt_id_d = grant_idx;
         if (state_q == IDLE) begin
            if (CAN_LOCK && !last[cand_idx]) begin
               state_d     = BURST;
               owner_d     = cand_idx;
               burst_cnt_d = 8'd1;
            end else begin
               rr_ptr_d = next_idx(cand_idx);
            end
         end else if (burst_done) begin
            state_d     = IDLE;
            rr_ptr_d    = next_idx(owner_q);
            burst_cnt_d = 8'd0;
         end else begin
            burst_cnt_d = burst_next[7:0];
         end
      end

      locked_d = (state_d == BURST);
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // value of the others, independent of statement order.
      if (rst) begin
         state_q     <= IDLE;
         owner_q     <= '0;
         rr_ptr_q    <= '0;
         burst_cnt_q <= 8'd0;
         gnt_id_q    <= '0;
         locked_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         rr_ptr_q    <= rr_ptr_d;
         burst_cnt_q <= burst_cnt_d;
         gnt_id_q    <= gnt_id_d;
         locked_q    <= locked_d;
      end
   end

   assign gnt_id = gnt_id_q;
   assign locked = locked_q;

endmodule

// File: tb/tb_q_wr_arbiter.sv
// Scoreboard bench for q_wr_arbiter: a 4-requester instance with MAX_BURST=4
// and a 3-requester instance for the non-power-of-two wrap.
module tb_q_wr_arbiter;

   localparam int W = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // 4-requester instance
   logic [3:0]   req4, last4, gnt4;
   logic [4*W-1:0] data4;
   logic         full4, locked4, q_wr4;
   logic [1:0]   gnt_id4;
   logic [W-1:0] q_data4;

   // 3-requester instance
   logic [2:0]   req3, last3, gnt3;
   logic [3*W-1:0] data3;
   logic         full3, locked3, q_wr3;
   logic [1:0]   gnt_id3;
   logic [W-1:0] q_data3;

   typedef struct {
      logic [3:0]   gnt;
      logic [W-1:0] data;
   } beat_t;

   beat_t sb4[$];
   beat_t sb3[$];

   int n_checks = 0;
   int n_errors = 0;

   q_wr_arbiter #(.NUM_REQ(4), .WORD_SZ(W), .MAX_BURST(4), .ID_W(2)) u_dut4 (
      .clk(clk), .rst(rst), .req(req4), .last(last4), .data_in(data4),
      .q_full(full4), .gnt(gnt4), .gnt_id(gnt_id4), .locked(locked4),
      .q_wr(q_wr4), .q_data(q_data4)
   );

   q_wr_arbiter #(.NUM_REQ(3), .WORD_SZ(W), .MAX_BURST(8), .ID_W(2)) u_dut3 (
      .clk(clk), .rst(rst), .req(req3), .last(last3), .data_in(data3),
      .q_full(full3), .gnt(gnt3), .gnt_id(gnt_id3), .locked(locked3),
      .q_wr(q_wr3), .q_data(q_data3)
   );

   function automatic logic [W-1:0] word4(input int i);
      return 32'hC0DE_0A00 + 32'(i);
   endfunction

   function automatic logic [W-1:0] word3(input int i);
      return 32'h3A3A_0000 + 32'(i);
   endfunction

   function automatic int idx_of(input logic [3:0] oh);
      for (int i = 0; i < 4; i++) if (oh[i]) return i;
      return 0;
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Monitors: pop the expected beat whenever a DUT issues a queue write.
   always @(negedge clk) begin
      beat_t b;
      if (q_wr4) begin
         if (sb4.size() == 0) begin
            check("dut4 unexpected write gnt", 64'(gnt4), 64'h0);
         end else begin
            b = sb4.pop_front();
            check("dut4 gnt", 64'(gnt4), 64'(b.gnt));
            check("dut4 q_data", 64'(q_data4), 64'(b.data));
         end
      end else if (gnt4 != 4'b0) begin
         check("dut4 gnt without q_wr", 64'(gnt4), 64'h0);
      end
   end

   always @(negedge clk) begin
      beat_t b;
      if (!rst) check("dut3 gnt_id range", 64'(gnt_id3 < 2'd3), 64'h1);
      if (q_wr3) begin
         if (sb3.size() == 0) begin
            check("dut3 unexpected write gnt", 64'(gnt3), 64'h0);
         end else begin
            b = sb3.pop_front();
            check("dut3 gnt", 64'(gnt3), 64'(b.gnt));
            check("dut3 q_data", 64'(q_data3), 64'(b.data));
         end
      end
   end

   // One cycle of stimulus for the 4-requester instance; eg is the expected grant.
   task automatic cyc4(input logic rs, input logic [3:0] r, input logic [3:0] l,
                       input logic f, input logic [3:0] eg);
      beat_t b;
      @(posedge clk); #1;
      rst = rs; req4 = r; last4 = l; full4 = f;
      if (eg != 4'b0) begin
         b.gnt  = eg;
         b.data = word4(idx_of(eg));
         sb4.push_back(b);
      end
      @(negedge clk);
   endtask

   task automatic cyc3(input logic rs, input logic [2:0] r, input logic [2:0] eg);
      beat_t b;
      @(posedge clk); #1;
      rst = rs; req3 = r; last3 = 3'b111; full3 = 1'b0;
      if (eg != 3'b0) begin
         b.gnt  = {1'b0, eg};
         b.data = word3(idx_of({1'b0, eg}));
         sb3.push_back(b);
      end
      @(negedge clk);
   endtask

   task automatic drain(input string name);
      #1;
      check(name, 64'(sb4.size() + sb3.size()), 64'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      req4 = '0; last4 = '0; full4 = 1'b0;
      req3 = '0; last3 = '0; full3 = 1'b0;
      for (int i = 0; i < 4; i++) data4[i*W +: W] = word4(i);
      for (int i = 0; i < 3; i++) data3[i*W +: W] = word3(i);

      // Reset with requests present: all outputs quiet.
      cyc4(1'b1, 4'b1111, 4'b1111, 1'b0, 4'b0000);
      req3 = 3'b111;
      cyc4(1'b1, 4'b1111, 4'b1111, 1'b0, 4'b0000);
      check("rst gnt",     64'(gnt4),    64'h0);
      check("rst q_wr",    64'(q_wr4),   64'h0);
      check("rst q_data",  64'(q_data4), 64'h0);
      check("rst locked",  64'(locked4), 64'h0);
      check("rst gnt_id",  64'(gnt_id4), 64'h0);
      check("rst gnt3",    64'(gnt3),    64'h0);
      req3 = 3'b000;

      // Single-beat packets from everyone: plain rotation 0,1,2,3,0.
      cyc4(1'b0, 4'b1111, 4'b1111, 1'b0, 4'b0001);
      cyc4(1'b0, 4'b1111, 4'b1111, 1'b0, 4'b0010);
      cyc4(1'b0, 4'b1111, 4'b1111, 1'b0, 4'b0100);
      cyc4(1'b0, 4'b1111, 4'b1111, 1'b0, 4'b1000);
      cyc4(1'b0, 4'b1111, 4'b1111, 1'b0, 4'b0001);
      check("rotate gnt_id", 64'(gnt_id4), 64'h3);
      check("rotate locked", 64'(locked4), 64'h0);
      cyc4(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000);
      check("rotate last gnt_id", 64'(gnt_id4), 64'h0);
      drain("rotate pending");

      // Three-beat packet from 2; requester 0 waits until the packet ends.
      cyc4(1'b0, 4'b0100, 4'b0000, 1'b0, 4'b0100);
      check("pkt locked beat1", 64'(locked4), 64'h0);
      cyc4(1'b0, 4'b0101, 4'b0000, 1'b0, 4'b0100);
      check("pkt locked beat2", 64'(locked4), 64'h1);
      check("pkt gnt_id beat2", 64'(gnt_id4), 64'h2);
      cyc4(1'b0, 4'b0101, 4'b0100, 1'b0, 4'b0100);
      check("pkt locked beat3", 64'(locked4), 64'h1);
      check("pkt gnt_id beat3", 64'(gnt_id4), 64'h2);
      cyc4(1'b0, 4'b0001, 4'b0001, 1'b0, 4'b0001);
      check("pkt released", 64'(locked4), 64'h0);
      drain("pkt pending");

      // Requester 1 never sends last: forced release after 4 beats, 3 is next.
      cyc4(1'b0, 4'b1010, 4'b0000, 1'b0, 4'b0010);
      cyc4(1'b0, 4'b1010, 4'b0000, 1'b0, 4'b0010);
      cyc4(1'b0, 4'b1010, 4'b0000, 1'b0, 4'b0010);
      cyc4(1'b0, 4'b1010, 4'b0000, 1'b0, 4'b0010);
      check("force locked beat4", 64'(locked4), 64'h1);
      cyc4(1'b0, 4'b1010, 4'b1000, 1'b0, 4'b1000);
      check("force released", 64'(locked4), 64'h0);
      check("force gnt_id", 64'(gnt_id4), 64'h1);
      cyc4(1'b0, 4'b0010, 4'b0010, 1'b0, 4'b0010);
      check("force single beat", 64'(locked4), 64'h0);
      cyc4(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000);
      drain("force pending");

      // Queue full for 5 cycles mid-burst: stall, keep lock and count.
      cyc4(1'b0, 4'b0100, 4'b0000, 1'b0, 4'b0100);
      for (int i = 0; i < 5; i++) begin
         cyc4(1'b0, 4'b0101, 4'b0000, 1'b1, 4'b0000);
         check("full locked", 64'(locked4), 64'h1);
         check("full q_wr",   64'(q_wr4),   64'h0);
         check("full gnt",    64'(gnt4),    64'h0);
      end
      for (int i = 0; i < 3; i++) begin
         cyc4(1'b0, 4'b0101, 4'b0000, 1'b0, 4'b0100);
         check("resume locked", 64'(locked4), 64'h1);
      end
      cyc4(1'b0, 4'b0101, 4'b0001, 1'b0, 4'b0001);
      check("resume released", 64'(locked4), 64'h0);
      cyc4(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000);
      drain("full pending");

      // Reset while locked: no grant, lock dropped, pointer back to 0.
      cyc4(1'b0, 4'b0010, 4'b0000, 1'b0, 4'b0010);
      cyc4(1'b1, 4'b0010, 4'b0000, 1'b0, 4'b0000);
      check("rstb locked before", 64'(locked4), 64'h1);
      check("rstb gnt", 64'(gnt4), 64'h0);
      cyc4(1'b0, 4'b1011, 4'b1111, 1'b0, 4'b0001);
      check("rstb locked after", 64'(locked4), 64'h0);
      check("rstb gnt_id", 64'(gnt_id4), 64'h0);
      cyc4(1'b0, 4'b1010, 4'b1111, 1'b0, 4'b0010);
      cyc4(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000);
      drain("rstb pending");

      // Three requesters, all busy: pointer wraps 2 -> 0.
      cyc3(1'b0, 3'b111, 3'b001);
      cyc3(1'b0, 3'b111, 3'b010);
      cyc3(1'b0, 3'b111, 3'b100);
      cyc3(1'b0, 3'b111, 3'b001);
      check("wrap3 gnt_id", 64'(gnt_id3), 64'h2);
      cyc3(1'b0, 3'b111, 3'b010);
      cyc3(1'b0, 3'b111, 3'b100);
      cyc3(1'b0, 3'b111, 3'b001);
      cyc3(1'b0, 3'b000, 3'b000);
      check("wrap3 last gnt_id", 64'(gnt_id3), 64'h0);
      drain("wrap3 pending");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
